ram_sdp_be: RTL and testbench

Parametrised simple-dual-port synchronous RAM: the successor to our single-port `ram`, with one write port and one read port that may be used together. It adds byte-enable writes, selectable read latency, defined read-during-write behaviour, and an optional hardware clear sequence after reset. It is the generic storage primitive for buffers and register files in the design.

---
 rtl/ram_sdp_be.sv | 155 +++++++++++++++
 tb/tb_ram_sdp_be.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle registered reads and selectable read-during-write.
// No backpressure: one write and one read per cycle in RUN; requests are dropped while init_busy is high.
module ram_sdp_be #(
   parameter int  ADDR_WIDTH    = 3,
   parameter int  DATA_WIDTH    = 8,
   parameter int  RD_LATENCY    = 1,
   parameter int  RDW_MODE      = 0,
   parameter int  INIT_ON_RESET = 1,
   localparam int NBYTES        = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [NBYTES-1:0]     wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  init_busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdat;
   logic [NBYTES-1:0]     mem_be;
   logic                  rd_go;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  s1_vld;
   logic [DATA_WIDTH-1:0] s1_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RST_STATE;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   // INIT borrows the write port to zero one word per cycle; user requests are dropped meanwhile.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      mem_we       = 1'b0;
      mem_addr     = wr_addr;
      mem_wdat     = wr_data;
      mem_be       = wr_be;
      rd_go        = 1'b0;
      case (state)
         ST_INIT: begin
            mem_we       = 1'b1;
            mem_addr     = init_cnt;
            mem_wdat     = '0;
            mem_be       = '1;
            init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
            if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            mem_we = wr_en;
            rd_go  = rd_en;
         end
      endcase
   end

   assign init_busy = (state == ST_INIT);

   // Array has no reset: contents survive rst and are only cleared by INIT.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (mem_be[i]) begin
               mem[mem_addr][8*i +: 8] <= mem_wdat[8*i +: 8];
            end
         end
      end
   end

   // Word captured at the request edge; bypass merges same-cycle written lanes.
   always_comb begin
      rd_word = mem[rd_addr];
      if ((RDW_MODE != 0) && mem_we && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
               rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else begin
         s1_vld <= rd_go;
         if (rd_go) begin
            s1_dat <= rd_word;
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_vld;
         logic [DATA_WIDTH-1:0] s2_dat;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_vld   <= 1'b0;
               s2_dat   <= '0;
               rd_valid <= 1'b0;
               rd_data  <= '0;
            end else begin
               s2_vld   <= s1_vld;
               if (s1_vld) begin
                  s2_dat <= s1_dat;
               end
               rd_valid <= s2_vld;
               if (s2_vld) begin
                  rd_data <= s2_dat;
               end
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_valid <= 1'b0;
               rd_data  <= '0;
            end else begin
               rd_valid <= s1_vld;
               if (s1_vld) begin
                  rd_data <= s1_dat;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (latency 1/old-data/clear-on-reset and latency 2/bypass/no-clear)
// share stimulus; a queue-based reference model checks every cycle alongside directed sequences.
module tb_ram_sdp_be;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        wr_en, rd_en;
   logic [2:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

   int checks   = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   ram_sdp_be #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)) dut_a (
      .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(busy_a));

   ram_sdp_be #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(0)) dut_b (
      .clk(clk), .rst(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(busy_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bm(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   // Reference model: per-instance word array with known-byte flags, and a queue of
   // pending results each stamped with the edge count at which it must appear.
   typedef struct {
      int          due;
      logic [31:0] dat;
      logic [3:0]  msk;
   } rd_t;

   rd_t         pend0[$];
   rd_t         pend1[$];
   rd_t         x;
   logic [31:0] mm [2][8];
   logic [3:0]  kn [2][8];
   logic        m_busy [2];
   int          m_cnt [2];
   logic        e_vld [2];
   logic [31:0] e_dat [2];
   logic [3:0]  e_msk [2];
   logic        r;
   int          cyc = 0;

   initial begin
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 8; a++) kn[d][a] = 4'h0;
   end

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         r = (d == 0) ? rst_a : rst_b;
         if (r) begin
            m_busy[d] = (d == 0);
            m_cnt[d]  = 0;
            e_vld[d]  = 1'b0;
            e_dat[d]  = '0;
            e_msk[d]  = 4'hF;
            if (d == 0) pend0.delete(); else pend1.delete();
         end else begin
            e_vld[d] = 1'b0;
            x.due = -1;
            if (d == 0) begin
               if (pend0.size() > 0 && pend0[0].due == cyc) x = pend0.pop_front();
            end else begin
               if (pend1.size() > 0 && pend1[0].due == cyc) x = pend1.pop_front();
            end
            if (x.due == cyc) begin
               e_vld[d] = 1'b1;
               e_dat[d] = x.dat;
               e_msk[d] = x.msk;
            end
            if (m_busy[d]) begin
               mm[d][m_cnt[d]] = '0;
               kn[d][m_cnt[d]] = 4'hF;
               m_cnt[d]++;
               if (m_cnt[d] == 8) m_busy[d] = 1'b0;
            end else begin
               if (rd_en) begin
                  x.due = cyc + ((d == 0) ? 1 : 2);
                  x.dat = mm[d][rd_addr];
                  x.msk = kn[d][rd_addr];
                  if (d == 1 && wr_en && wr_addr == rd_addr) begin
                     for (int i = 0; i < 4; i++) begin
                        if (wr_be[i]) begin
                           x.dat[8*i +: 8] = wr_data[8*i +: 8];
                           x.msk[i] = 1'b1;
                        end
                     end
                  end
                  if (d == 0) pend0.push_back(x); else pend1.push_back(x);
               end
               if (wr_en) begin
                  for (int i = 0; i < 4; i++) begin
                     if (wr_be[i]) begin
                        mm[d][wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                        kn[d][wr_addr][i] = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("mdl_busy_a",  32'(busy_a),     32'(m_busy[0]));
         chk("mdl_valid_a", 32'(rd_valid_a), 32'(e_vld[0]));
         chk("mdl_data_a",  rd_data_a & bm(e_msk[0]), e_dat[0] & bm(e_msk[0]));
         chk("mdl_busy_b",  32'(busy_b),     32'(m_busy[1]));
         chk("mdl_valid_b", 32'(rd_valid_b), 32'(e_vld[1]));
         chk("mdl_data_b",  rd_data_b & bm(e_msk[1]), e_dat[1] & bm(e_msk[1]));
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        re;
      logic [2:0]  ra;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   task automatic idle();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      int          n;
      int          pulses;
      logic [31:0] got;
      logic        sv_a [12];
      logic        sv_b [12];
      logic [31:0] sd_a [12];
      logic [31:0] sd_b [12];
      vec_t        tab [10];

      tab[0] = '{1'b1, 3'd2, 32'hAABBCCDD, 4'hF, 1'b0, 3'd0, 32'h0,        32'h0};
      tab[1] = '{1'b1, 3'd2, 32'h11223344, 4'h5, 1'b0, 3'd0, 32'h0,        32'h0};
      tab[2] = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd2, 32'hAA22CC44, 32'hAA22CC44};
      tab[3] = '{1'b1, 3'd5, 32'h0000000F, 4'hF, 1'b0, 3'd0, 32'h0,        32'h0};
      tab[4] = '{1'b1, 3'd5, 32'h000000F0, 4'h1, 1'b1, 3'd5, 32'h0000000F, 32'h000000F0};
      tab[5] = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd5, 32'h000000F0, 32'h000000F0};
      tab[6] = '{1'b1, 3'd3, 32'h12345678, 4'h0, 1'b1, 3'd3, 32'h00000013, 32'h00000013};
      tab[7] = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd3, 32'h00000013, 32'h00000013};
      tab[8] = '{1'b1, 3'd1, 32'hDEADBEEF, 4'hA, 1'b1, 3'd6, 32'h00000016, 32'h00000016};
      tab[9] = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd1, 32'hDE00BE11, 32'hDE00BE11};

      rst_a = 1'b1; rst_b = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy_a",  32'(busy_a), 32'd1);
      chk("rst_busy_b",  32'(busy_b), 32'd0);
      chk("rst_valid_a", 32'(rd_valid_a), 32'd0);
      chk("rst_valid_b", 32'(rd_valid_b), 32'd0);
      chk("rst_data_a",  rd_data_a, 32'h0);
      chk("rst_data_b",  rd_data_b, 32'h0);

      // INIT length and dropped reads during INIT
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rd_en = 1'b1; rd_addr = 3'd3;
      n = 0; pulses = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (rd_valid_a) pulses++;
      end while (busy_a && n < 20);
      rd_en = 1'b0;
      chk("init_cycles", 32'(n), 32'd8);
      chk("init_rd_pulses", 32'(pulses), 32'd0);

      for (int a = 0; a < 8; a++) begin
         @(negedge clk); rd_en = 1'b1; rd_addr = 3'(a);
         @(negedge clk); rd_en = 1'b0;
         pulses = 0; got = 32'hFFFFFFFF;
         repeat (3) begin
            if (rd_valid_a) begin pulses++; got = rd_data_a; end
            @(negedge clk);
         end
         chk("clear_pulses", 32'(pulses), 32'd1);
         chk("clear_data", got, 32'h0);
      end

      for (int a = 0; a < 8; a++) begin
         @(negedge clk); wr_en = 1'b1; wr_addr = 3'(a); wr_data = 32'h10 + 32'(a); wr_be = 4'hF;
      end

      // back-to-back reads of 0..7
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         sv_a[k] = rd_valid_a; sd_a[k] = rd_data_a;
         sv_b[k] = rd_valid_b; sd_b[k] = rd_data_b;
         wr_en = 1'b0;
         rd_en = (k < 8);
         rd_addr = 3'(k);
      end
      for (int k = 0; k < 12; k++) begin
         chk("b2b_valid_b", 32'(sv_b[k]), 32'(k >= 3 && k <= 10));
         if (k >= 3 && k <= 10) chk("b2b_data_b", sd_b[k], 32'h10 + 32'(k - 3));
         chk("b2b_valid_a", 32'(sv_a[k]), 32'(k >= 2 && k <= 9));
         if (k >= 2 && k <= 9) chk("b2b_data_a", sd_a[k], 32'h10 + 32'(k - 2));
      end

      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         wr_en = tab[t].we; wr_addr = tab[t].wa; wr_data = tab[t].wd; wr_be = tab[t].be;
         rd_en = tab[t].re; rd_addr = tab[t].ra;
         @(negedge clk); idle();
         @(negedge clk);
         if (tab[t].re) begin
            chk("vec_valid_a", 32'(rd_valid_a), 32'd1);
            chk("vec_data_a", rd_data_a, tab[t].exp_a);
         end
         @(negedge clk);
         if (tab[t].re) begin
            chk("vec_valid_b", 32'(rd_valid_b), 32'd1);
            chk("vec_data_b", rd_data_b, tab[t].exp_b);
         end
      end

      // retention across rst without clear, plus a be=0 write
      @(negedge clk); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h5A; wr_be = 4'hF;
      @(negedge clk); wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
      @(negedge clk); idle(); rst_b = 1'b1;
      #1 chk("noinit_busy_rst", 32'(busy_b), 32'd0);
      @(negedge clk); rst_b = 1'b0; rd_en = 1'b1; rd_addr = 3'd4;
      chk("noinit_busy_rel", 32'(busy_b), 32'd0);
      @(negedge clk); rd_en = 1'b0;
      @(negedge clk); chk("be0_data_a", rd_data_a, 32'h5A);
      @(negedge clk); chk("retain_data_b", rd_data_b, 32'h5A);

      // rst at INIT step 4 restarts the whole sequence
      @(negedge clk); rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); rst_a = 1'b1;
      #1 chk("midinit_busy", 32'(busy_a), 32'd1);
      @(negedge clk); rst_a = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy_a && n < 20);
      chk("reinit_cycles", 32'(n), 32'd8);
      @(negedge clk); rd_en = 1'b1; rd_addr = 3'd2;
      @(negedge clk); rd_en = 1'b0;
      @(negedge clk); chk("reinit_data_a", rd_data_a, 32'h0);
      @(negedge clk); chk("keep_data_b", rd_data_b, 32'hAA22CC44);

      // rst with reads in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); rd_en = 1'b1; rd_addr = 3'(k + 1);
      end
      @(negedge clk); idle();
      chk("pre_rst_valid_b", 32'(rd_valid_b), 32'd1);
      rst_b = 1'b1;
      #1;
      chk("flight_valid_b", 32'(rd_valid_b), 32'd0);
      chk("flight_data_b", rd_data_b, 32'h0);
      @(negedge clk); rst_b = 1'b0;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (rd_valid_b) pulses++;
      end
      chk("flight_stale", 32'(pulses), 32'd0);

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         wr_en   = ($urandom_range(0, 3) != 0);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = $urandom;
         wr_be   = 4'($urandom);
         rd_en   = ($urandom_range(0, 3) != 0);
         rd_addr = 3'($urandom_range(0, 7));
      end
      @(negedge clk); idle();
      repeat (4) @(negedge clk);
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
